// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame geometry and frame builder.
package uart_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam logic [FRAME_BITS-1:0] IDLE_FRAME = 11'h7FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Even parity over the active data bits, inverted for odd sense.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic       eight,
                                      input logic       ohel);
    logic [7:0] bits;
    bits = data;
    if (!eight) bits[7] = 1'b0;
    return (^bits) ^ ohel;
  endfunction

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data,
                                                        input logic       eight,
                                                        input logic       pen,
                                                        input logic       ohel);
    logic par_slot;
    par_slot = pen ? parity_bit(data, eight, ohel) : 1'b1;
    if (eight) return {1'b1, par_slot, data, 1'b0};
    return {2'b11, par_slot, data[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-period counter: emits a one-cycle tick every BAUD_DIV enabled cycles; clr restarts the period.
module uart_baud_gen #(
  parameter int unsigned BAUD_DIV = 10416
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_c = en && !clr && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)         cnt_d = '0;
    else if (tick_c) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX sequencer: accepts a byte, builds the 11-bit frame, then strobes ld once and sh per bit.
// Optional parity: define UART_TX_PARITY_EN to honour pen/ohel; otherwise the parity slot is a stop bit.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 10416
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  input  logic [7:0]            tx_data,
  input  logic                  eight,
  input  logic                  pen,
  input  logic                  ohel,
  output logic                  tx_ready,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  ld,
  output logic                  sh,
  output logic                  tx_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic                    tx_ready_q, tx_ready_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic                    ld_q, ld_d;
  logic                    sh_q, sh_d;
  logic                    tx_done_q, tx_done_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                    accept_c, tick_c, pen_c;

`ifdef UART_TX_PARITY_EN
  assign pen_c = pen;
`else
  logic unused_pen_c;
  assign unused_pen_c = pen;
  assign pen_c        = 1'b0;
`endif

  assign accept_c = tx_valid && tx_ready_q;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == ST_SEND),
    .clr    (state_q == ST_LOAD),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_ready_q <= 1'b1;
      frame_q    <= IDLE_FRAME;
      ld_q       <= 1'b0;
      sh_q       <= 1'b0;
      tx_done_q  <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_ready_q <= tx_ready_d;
      frame_q    <= frame_d;
      ld_q       <= ld_d;
      sh_q       <= sh_d;
      tx_done_q  <= tx_done_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  // SEND ends in the cycle the final sh/tx_done is visible, so tx_ready follows one cycle later.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept_c)  state_d = ST_LOAD;
      ST_LOAD:                state_d = ST_SEND;
      ST_SEND: if (tx_done_q) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_ready_d = (state_d == ST_IDLE);
    frame_d    = frame_q;
    ld_d       = (state_q == ST_LOAD);
    sh_d       = tick_c;
    tx_done_d  = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    if (accept_c) frame_d = build_frame(tx_data, eight, pen_c, ohel);
    if (state_q == ST_LOAD) begin
      bit_cnt_d = '0;
    end else if (tick_c) begin
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        tx_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      end
    end
  end

  assign tx_ready = tx_ready_q;
  assign frame    = frame_q;
  assign ld       = ld_q;
  assign sh       = sh_q;
  assign tx_done  = tx_done_q;

endmodule
